// File: rtl/rej_sampler_sched_pkg.sv
// Shared definitions for the rejection-sampler scheduler.
//   L, K      default poly counts for s1 / s2
//   ETA       secret coefficient bound of the default parameter set
//   NONCE_W   nonce field width appended above the seed
//   RHO_W     seed width
//   TMO_W     per-poly watchdog width
//   sched_state_t  scheduler FSM states
//   poly_tag_t     {sel, idx} tag handed to the coefficient store
package rej_sampler_sched_pkg;

  localparam int unsigned L       = 4;
  localparam int unsigned K       = 4;
  localparam int unsigned ETA     = 2;
  localparam int unsigned NONCE_W = 16;
  localparam int unsigned RHO_W   = 512;
  localparam int unsigned TMO_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE,
    ST_FIN,
    ST_TMO
  } sched_state_t;

  typedef struct packed {
    logic       sel;
    logic [2:0] idx;
  } poly_tag_t;

  // Nonces 0..l-1 are s1[nonce]; nonces l.. are s2[nonce-l].
  function automatic poly_tag_t nonce_to_tag(input logic [7:0] nonce, input logic [7:0] l);
    poly_tag_t t;
    t.sel = (nonce >= l);
    t.idx = 3'(t.sel ? nonce - l : nonce);
    return t;
  endfunction

endpackage

// File: rtl/rej_sampler_sched_wdog_cnt.sv
// Per-poly watchdog counter.
//   clk  clock
//   rst  synchronous active-high reset
//   clr  restart count from zero
//   en   count one cycle (holds once saturated)
//   sat  count is all-ones
module wdog_cnt #(
  parameter int unsigned TMO_W = rej_sampler_sched_pkg::TMO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sat
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  assign sat = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !sat) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rej_sampler_sched.sv
// Sequences one shared bounded-rejection sampler core over the L+K secret
// polynomials of key generation, tagging each result as s1[i] or s2[j].
//   clk, rst    clock, synchronous active-high reset
//   start, rho  launch request (IDLE only) and seed captured with it
//   core_start  one-cycle launch pulse to the sampler core
//   core_seed   {nonce, rho_q}, stable from core_start until core_done
//   core_done   core has a finished poly on its data bus this cycle
//   poly_we     one-cycle store strobe qualifying poly_sel / poly_idx
//   poly_sel    0 = s1, 1 = s2; poly_idx index within that vector
//   busy, done  operation in flight / one-cycle completion pulse
//   err         sticky watchdog timeout, cleared by the next accepted start
module rej_sampler_sched #(
  parameter int unsigned L       = rej_sampler_sched_pkg::L,
  parameter int unsigned K       = rej_sampler_sched_pkg::K,
  parameter int unsigned RHO_W   = rej_sampler_sched_pkg::RHO_W,
  parameter int unsigned NONCE_W = rej_sampler_sched_pkg::NONCE_W,
  parameter int unsigned TMO_W   = rej_sampler_sched_pkg::TMO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RHO_W-1:0]         rho,
  output logic                     core_start,
  output logic [NONCE_W+RHO_W-1:0] core_seed,
  input  logic                     core_done,
  output logic                     poly_we,
  output logic                     poly_sel,
  output logic [2:0]               poly_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  import rej_sampler_sched_pkg::*;

  sched_state_t     state_q, state_d;
  logic [7:0]       nonce_q, nonce_d;
  logic [RHO_W-1:0] rho_q, rho_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             core_start_q, core_start_d;
  logic             poly_we_q, poly_we_d;
  poly_tag_t        tag_q, tag_d;
  logic             wd_clr, wd_en, wd_sat;

  wdog_cnt #(
    .TMO_W(TMO_W)
  ) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .sat(wd_sat)
  );

  // Pulse outputs are registered on entry to their state so they are high
  // for exactly the cycle the FSM spends in LAUNCH / WRITE / FIN.
  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    rho_d        = rho_q;
    busy_d       = busy_q;
    err_d        = err_q;
    done_d       = 1'b0;
    core_start_d = 1'b0;
    poly_we_d    = 1'b0;
    tag_d        = tag_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rho_d        = rho;
          nonce_d      = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          core_start_d = 1'b1;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // A completion on the saturation cycle still counts.
        if (core_done) begin
          poly_we_d = 1'b1;
          tag_d     = nonce_to_tag(nonce_q, 8'(L));
          state_d   = ST_WRITE;
        end else if (wd_sat) begin
          state_d = ST_TMO;
        end
      end
      ST_WRITE: begin
        if (nonce_q == 8'(L + K - 1)) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          nonce_d      = nonce_q + 8'd1;
          core_start_d = 1'b1;
          state_d      = ST_LAUNCH;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_TMO: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      nonce_q      <= '0;
      rho_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      poly_we_q    <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      nonce_q      <= nonce_d;
      rho_q        <= rho_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      poly_we_q    <= poly_we_d;
      tag_q        <= tag_d;
    end
  end

  assign core_start = core_start_q;
  assign core_seed  = {{(NONCE_W - 8){1'b0}}, nonce_q, rho_q};
  assign poly_we    = poly_we_q;
  assign poly_sel   = tag_q.sel;
  assign poly_idx   = tag_q.idx;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rej_sampler_sched.sv
module tb_rej_sampler_sched;

  localparam int unsigned RW = 512;
  localparam int unsigned NW = 16;
  localparam int unsigned SW = RW + NW;
  localparam int unsigned TW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, core_done, use_b;
  logic [RW-1:0] rho;

  logic a_start, a_cd, b_start, b_cd;
  assign a_start = start & ~use_b;
  assign a_cd    = core_done & ~use_b;
  assign b_start = start & use_b;
  assign b_cd    = core_done & use_b;

  logic          a_core_start, a_poly_we, a_poly_sel, a_busy, a_done, a_err;
  logic [2:0]    a_poly_idx;
  logic [SW-1:0] a_core_seed;
  logic          b_core_start, b_poly_we, b_poly_sel, b_busy, b_done, b_err;
  logic [2:0]    b_poly_idx;
  logic [SW-1:0] b_core_seed;

  rej_sampler_sched #(.L(4), .K(4), .RHO_W(RW), .NONCE_W(NW), .TMO_W(TW)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .rho(rho),
    .core_start(a_core_start), .core_seed(a_core_seed), .core_done(a_cd),
    .poly_we(a_poly_we), .poly_sel(a_poly_sel), .poly_idx(a_poly_idx),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  rej_sampler_sched #(.L(7), .K(8), .RHO_W(RW), .NONCE_W(NW), .TMO_W(TW)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .rho(rho),
    .core_start(b_core_start), .core_seed(b_core_seed), .core_done(b_cd),
    .poly_we(b_poly_we), .poly_sel(b_poly_sel), .poly_idx(b_poly_idx),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  logic          m_core_start, m_poly_we, m_poly_sel, m_busy, m_done, m_err;
  logic [2:0]    m_poly_idx;
  logic [SW-1:0] m_core_seed;
  assign m_core_start = use_b ? b_core_start : a_core_start;
  assign m_poly_we    = use_b ? b_poly_we    : a_poly_we;
  assign m_poly_sel   = use_b ? b_poly_sel   : a_poly_sel;
  assign m_poly_idx   = use_b ? b_poly_idx   : a_poly_idx;
  assign m_busy       = use_b ? b_busy       : a_busy;
  assign m_done       = use_b ? b_done       : a_done;
  assign m_err        = use_b ? b_err        : a_err;
  assign m_core_seed  = use_b ? b_core_seed  : a_core_seed;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Per-run stimulus and observations.
  int         lat_q[$];        // core answer delay per launch, 0 = never answers
  bit         spur_launch, spur_start;
  logic [3:0] obs_tag[$];
  int         obs_nonce[$];
  int         n_done, first_launch_c, last_launch_c, end_c;
  bit         seed_bad, err_end, err_first, ended;

  // Reference tag: nonce n < l goes to s1[n], otherwise s2[n-l].
  function automatic logic [3:0] model_tag(input int n, input int l);
    logic [2:0] i;
    i = (n >= l) ? 3'(n - l) : 3'(n);
    return {logic'(n >= l), i};
  endfunction

  function automatic logic [RW-1:0] rand_seed();
    logic [RW-1:0] s;
    for (int i = 0; i < 16; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // One accepted start, then a cycle-by-cycle core responder until busy falls
  // or the budget runs out.
  task automatic run_op(input logic [RW-1:0] seed, input int budget);
    int cnt;
    int li;
    obs_tag.delete(); obs_nonce.delete();
    n_done = 0; seed_bad = 0; ended = 0; cnt = 0; li = 0;
    first_launch_c = -1; last_launch_c = -1; end_c = -1;
    @(negedge clk); rho = seed; start = 1'b1;
    @(negedge clk); start = 1'b0; rho = ~seed;
    for (int c = 0; c < budget; c++) begin
      core_done = 1'b0;
      start     = 1'b0;
      if (c == 0) err_first = m_err;
      if (!m_busy) begin
        ended = 1; end_c = c; err_end = m_err;
        break;
      end
      if (m_poly_we) obs_tag.push_back({m_poly_sel, m_poly_idx});
      if (m_done) n_done++;
      if (m_core_start) begin
        obs_nonce.push_back(int'(m_core_seed[SW-1:RW]));
        if (m_core_seed[RW-1:0] !== seed) seed_bad = 1;
        if (first_launch_c < 0) first_launch_c = c;
        last_launch_c = c;
        cnt = (li < lat_q.size()) ? lat_q[li] : 0;
        li++;
        if (spur_launch) core_done = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_done = 1'b1;
      end
      if (spur_start && c == 7) start = 1'b1;
      @(negedge clk);
    end
    core_done = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; core_done = 1'b0; use_b = 1'b0; rho = '1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_core_start, a_poly_we, a_poly_sel, a_poly_idx, a_busy, a_done, a_err} !== 9'b0 || a_core_seed !== '0)
      $display("FAIL reset_a: ctl=%b seed=%h required all zero",
               {a_core_start, a_poly_we, a_poly_sel, a_poly_idx, a_busy, a_done, a_err}, a_core_seed);
    else n_pass++;
    n_chk++;
    if ({b_core_start, b_poly_we, b_poly_sel, b_poly_idx, b_busy, b_done, b_err} !== 9'b0 || b_core_seed !== '0)
      $display("FAIL reset_b: ctl=%b seed=%h required all zero",
               {b_core_start, b_poly_we, b_poly_sel, b_poly_idx, b_busy, b_done, b_err}, b_core_seed);
    else n_pass++;
    rst = 1'b0; start = 1'b0; rho = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    lat_q.delete();
    for (int i = 0; i < 8; i++) lat_q.push_back(20);
    spur_launch = 0; spur_start = 0; use_b = 1'b0;
    run_op({64{8'hA5}}, 400);
    n_chk++; if (!ended) $display("FAIL t1_end: busy never fell"); else n_pass++;
    n_chk++; if (obs_tag.size() != 8) $display("FAIL t1_writes: got %0d required 8", obs_tag.size()); else n_pass++;
    for (int i = 0; i < obs_tag.size() && i < 8; i++) begin
      n_chk++;
      if (obs_tag[i] !== model_tag(i, 4)) $display("FAIL t1_tag[%0d]: got %h required %h", i, obs_tag[i], model_tag(i, 4));
      else n_pass++;
    end
    n_chk++; if (obs_nonce.size() != 8) $display("FAIL t1_launches: got %0d required 8", obs_nonce.size()); else n_pass++;
    for (int i = 0; i < obs_nonce.size() && i < 8; i++) begin
      n_chk++; if (obs_nonce[i] != i) $display("FAIL t1_nonce[%0d]: got %0d required %0d", i, obs_nonce[i], i); else n_pass++;
    end
    n_chk++; if (seed_bad) $display("FAIL t1_seed: rho field got corrupted required %h", {64{8'hA5}}); else n_pass++;
    n_chk++; if (n_done != 1) $display("FAIL t1_done: got %0d pulses required 1", n_done); else n_pass++;
    n_chk++; if (err_end !== 1'b0) $display("FAIL t1_err: got %b required 0", err_end); else n_pass++;
    // Busy span: per poly LAUNCH + 19 waiting cycles + detect + WRITE, plus FIN.
    n_chk++;
    if (end_c - first_launch_c != 8 * (19 + 3) + 1)
      $display("FAIL t1_busy_span: got %0d required %0d", end_c - first_launch_c, 8 * (19 + 3) + 1);
    else n_pass++;
  endtask

  task automatic test_spurious();
    logic [RW-1:0] s;
    use_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      n_chk++;
      if ({a_poly_we, a_busy, a_core_start, a_done} !== 4'b0)
        $display("FAIL t5_idle_done[%0d]: we/busy/start/done=%b required 0000", i, {a_poly_we, a_busy, a_core_start, a_done});
      else n_pass++;
    end
    lat_q.delete();
    for (int i = 0; i < 8; i++) lat_q.push_back(20);
    spur_launch = 1; spur_start = 1;
    s = rand_seed();
    run_op(s, 400);
    spur_launch = 0; spur_start = 0;
    n_chk++; if (obs_tag.size() != 8) $display("FAIL t5_writes: got %0d required 8", obs_tag.size()); else n_pass++;
    for (int i = 0; i < obs_tag.size() && i < 8; i++) begin
      n_chk++;
      if (obs_tag[i] !== model_tag(i, 4)) $display("FAIL t5_tag[%0d]: got %h required %h", i, obs_tag[i], model_tag(i, 4));
      else n_pass++;
    end
    for (int i = 0; i < obs_nonce.size() && i < 8; i++) begin
      n_chk++; if (obs_nonce[i] != i) $display("FAIL t5_nonce[%0d]: got %0d required %0d", i, obs_nonce[i], i); else n_pass++;
    end
    n_chk++; if (seed_bad) $display("FAIL t5_seed: rho field changed by ignored start required %h", s); else n_pass++;
    n_chk++; if (n_done != 1) $display("FAIL t5_done: got %0d pulses required 1", n_done); else n_pass++;
  endtask

  task automatic test_rst_mid();
    lat_q.delete();
    lat_q.push_back(20); lat_q.push_back(20); lat_q.push_back(20); lat_q.push_back(0);
    use_b = 1'b0;
    run_op(rand_seed(), 80);
    n_chk++; if (obs_nonce.size() != 4) $display("FAIL t4_pre_launches: got %0d required 4", obs_nonce.size()); else n_pass++;
    // Abort in WAIT of nonce 3, with a start on the same edge that must be dropped.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_chk++;
    if ({a_core_start, a_poly_we, a_poly_sel, a_poly_idx, a_busy, a_done, a_err} !== 9'b0 || a_core_seed !== '0)
      $display("FAIL t4_rst_outputs: ctl=%b seed=%h required all zero",
               {a_core_start, a_poly_we, a_poly_sel, a_poly_idx, a_busy, a_done, a_err}, a_core_seed);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({a_busy, a_core_start} !== 2'b00) $display("FAIL t4_start_dropped: busy/start=%b required 00", {a_busy, a_core_start});
    else n_pass++;
    lat_q.delete();
    for (int i = 0; i < 8; i++) lat_q.push_back(5 + i);
    run_op(rand_seed(), 400);
    n_chk++; if (obs_nonce.size() != 8) $display("FAIL t4_restart_launches: got %0d required 8", obs_nonce.size()); else n_pass++;
    for (int i = 0; i < obs_nonce.size() && i < 8; i++) begin
      n_chk++; if (obs_nonce[i] != i) $display("FAIL t4_nonce[%0d]: got %0d required %0d", i, obs_nonce[i], i); else n_pass++;
    end
    n_chk++; if (obs_tag.size() != 8 || n_done != 1) $display("FAIL t4_restart: writes=%0d done=%0d required 8/1", obs_tag.size(), n_done); else n_pass++;
  endtask

  task automatic test_param_build();
    logic [RW-1:0] s;
    lat_q.delete();
    for (int i = 0; i < 15; i++) lat_q.push_back(int'($urandom_range(300, 5)));
    use_b = 1'b1;
    s = rand_seed();
    run_op(s, 5000);
    use_b = 1'b0;
    n_chk++; if (!ended) $display("FAIL t2_end: busy never fell"); else n_pass++;
    n_chk++; if (obs_tag.size() != 15) $display("FAIL t2_writes: got %0d required 15", obs_tag.size()); else n_pass++;
    for (int i = 0; i < obs_tag.size() && i < 15; i++) begin
      n_chk++;
      if (obs_tag[i] !== model_tag(i, 7)) $display("FAIL t2_tag[%0d]: got %h required %h", i, obs_tag[i], model_tag(i, 7));
      else n_pass++;
    end
    for (int i = 0; i < obs_nonce.size() && i < 15; i++) begin
      n_chk++; if (obs_nonce[i] != i) $display("FAIL t2_nonce[%0d]: got %0d required %0d", i, obs_nonce[i], i); else n_pass++;
    end
    n_chk++; if (seed_bad) $display("FAIL t2_seed: rho field corrupted required %h", s); else n_pass++;
    n_chk++; if (n_done != 1 || err_end !== 1'b0) $display("FAIL t2_done_err: done=%0d err=%b required 1/0", n_done, err_end); else n_pass++;
  endtask

  task automatic test_timeout();
    lat_q.delete();
    lat_q.push_back(20); lat_q.push_back(20); lat_q.push_back(0);
    use_b = 1'b0;
    run_op(rand_seed(), 6000);
    n_chk++; if (!ended) $display("FAIL t3_end: busy never fell"); else n_pass++;
    n_chk++; if (err_end !== 1'b1) $display("FAIL t3_err: got %b required 1", err_end); else n_pass++;
    n_chk++; if (n_done != 0) $display("FAIL t3_done: got %0d pulses required 0", n_done); else n_pass++;
    n_chk++; if (obs_tag.size() != 2) $display("FAIL t3_writes: got %0d required 2", obs_tag.size()); else n_pass++;
    n_chk++; if (obs_nonce.size() != 3) $display("FAIL t3_launches: got %0d required 3", obs_nonce.size()); else n_pass++;
    // 2**TW WAIT cycles, then one TMO cycle before busy drops.
    n_chk++;
    if (end_c - last_launch_c != (1 << TW) + 2)
      $display("FAIL t3_tmo_time: got %0d required %0d", end_c - last_launch_c, (1 << TW) + 2);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++; if (a_err !== 1'b1) $display("FAIL t3_err_sticky: got %b required 1", a_err); else n_pass++;
  endtask

  task automatic test_done_on_sat();
    lat_q.delete();
    lat_q.push_back(20); lat_q.push_back(20); lat_q.push_back(1 << TW);
    for (int i = 3; i < 8; i++) lat_q.push_back(20);
    use_b = 1'b0;
    run_op(rand_seed(), 6000);
    n_chk++; if (err_first !== 1'b0) $display("FAIL t6_err_cleared: got %b required 0", err_first); else n_pass++;
    n_chk++; if (obs_tag.size() != 8) $display("FAIL t6_writes: got %0d required 8", obs_tag.size()); else n_pass++;
    n_chk++; if (err_end !== 1'b0 || n_done != 1) $display("FAIL t6_err_done: err=%b done=%0d required 0/1", err_end, n_done); else n_pass++;
    // One cycle later than the saturation cycle is too late.
    lat_q.delete();
    lat_q.push_back((1 << TW) + 1);
    run_op(rand_seed(), 6000);
    n_chk++;
    if (err_end !== 1'b1 || obs_tag.size() != 0 || n_done != 0)
      $display("FAIL t6_late_done: err=%b writes=%0d done=%0d required 1/0/0", err_end, obs_tag.size(), n_done);
    else n_pass++;
  endtask

  initial begin
    spur_launch = 0; spur_start = 0;
    test_reset();
    test_basic();
    test_spurious();
    test_rst_mid();
    test_param_build();
    test_timeout();
    test_done_on_sat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
